iq_buf_reader: RTL and testbench
================================

IQ_BUF_READER -- requirements
Module: iq_buf_reader

Interface
REQ-001 Parameter: READ_LATENCY, default 1, BSRAM read latency in clk cycles from ram_addr change to valid ram_dout_*; legal values 1 or 2.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin playback; sampled only in IDLE.
REQ-005 abort  input  1  terminate playback immediately; no done pulse.
REQ-006 start_addr  input  9  first buffer word address, latched on accepted start.
REQ-007 num_words  input  9  number of 36-bit words to play, latched on accepted start; 0 is legal.
REQ-008 ram_addr  output  9  read address to I and Q BSRAMs, shared.
REQ-009 ram_dout_i  input  36  packed I word from BSRAM.
REQ-010 ram_dout_q  input  36  packed Q word from BSRAM.
REQ-011 smp_valid  output  1  sample available.
REQ-012 smp_ready  input  1  downstream accepts sample when high with smp_valid.
REQ-013 smp_i  output  1  I sample bit.
REQ-014 smp_q  output  1  Q sample bit.
REQ-015 smp_last  output  1  high with the final sample of the run.
REQ-016 busy  output  1  high from accepted start until return to IDLE.
REQ-017 done  output  1  one-cycle pulse on normal completion.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, STREAM, FINISH.
REQ-019 IDLE: start=1 with num_words!=0 -> FETCH, latch start_addr/num_words, busy=1 next cycle.
REQ-020 IDLE: start=1 with num_words=0 -> FINISH directly; no RAM read, no samples.
REQ-021 FETCH: drive ram_addr=current address, wait READ_LATENCY cycles, load ram_dout_i/q into shift register, -> STREAM.
REQ-022 STREAM: bit k (k=0..35) of the loaded word SHALL be emitted as the k-th sample, LSB first; smp_i/smp_q taken from the same bit index.
REQ-023 Sample advance only on smp_valid & smp_ready; smp_i, smp_q, smp_last SHALL hold stable while smp_valid & ~smp_ready.
REQ-024 Prefetch: during STREAM the next word SHALL be read into a one-word holding buffer so that, with smp_ready held high, bit 35 of word n is followed by bit 0 of word n+1 in the next cycle with no valid gap.
REQ-025 Address SHALL increment modulo 512 per word (511 wraps to 0); no more than num_words words are read.
REQ-026 smp_last SHALL be high exactly on bit 35 of word num_words-1.
REQ-027 Acceptance of the smp_last sample -> FINISH; FINISH drives done=1 for one cycle, busy=0, -> IDLE.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state -> IDLE next cycle: smp_valid=0, busy=0, done=0, holding buffer invalidated; abort takes priority over simultaneous start, handshake or completion.
REQ-030 Total samples per run SHALL equal 36*num_words.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, ram_addr=0, smp_valid=0, smp_i=0, smp_q=0, smp_last=0, busy=0, done=0, shift/holding registers and counters cleared.
REQ-032 Reset mid-run SHALL discard the run; after release the block waits in IDLE for a new start.

Verification
REQ-033 RAM model word 0 I=36'h0_0000_0001, Q=36'h8_0000_0000, start_addr=0, num_words=1, smp_ready=1 -> 36 samples; sample 0 i=1 q=0, sample 35 i=0 q=1 with smp_last=1, done one cycle later.
REQ-034 start_addr=510, num_words=3, smp_ready=1 -> ram_addr sequence 510, 511, 0; 108 consecutive smp_valid cycles with no gap after first sample; single done.
REQ-035 num_words=0 start -> no smp_valid, done pulse within 2 cycles, busy high for at most 2 cycles.
REQ-036 smp_ready random 50% duty, num_words=4 -> exactly 144 accepted samples matching RAM contents in order; outputs stable during stall cycles.
REQ-037 abort asserted after 40 accepted samples of num_words=4 -> smp_valid=0 and busy=0 next cycle, no done; subsequent start of num_words=1 plays correctly.
REQ-038 rst pulsed low mid-STREAM, both READ_LATENCY=1 and 2 -> all outputs at reset values asynchronously; clean restart on next start.

Source files
------------

// File: rtl/iq_buf_reader.sv
// iq_buf_reader: plays a run of 36-bit I/Q word pairs from shared-address
// BSRAMs as a 1-bit-per-cycle I/Q sample stream with valid/ready handshake.
// One word is shifted out while the next one is prefetched into a holding
// buffer, so a steady-ready consumer sees no gap between words.
module iq_buf_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [8:0]  start_addr,
  input  logic [8:0]  num_words,
  output logic [8:0]  ram_addr,
  input  logic [35:0] ram_dout_i,
  input  logic [35:0] ram_dout_q,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic        smp_i,
  output logic        smp_q,
  output logic        smp_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_t;

  state_t              state_q, state_d;
  logic [8:0]          addr_q, addr_d;
  logic [8:0]          rd_left_q, rd_left_d;     // words still to be read
  logic [8:0]          emit_left_q, emit_left_d; // words still to be emitted, incl. current
  logic [5:0]          bit_q, bit_d;
  logic [35:0]         sh_i_q, sh_i_d, sh_q_q, sh_q_d;
  logic [35:0]         hb_i_q, hb_i_d, hb_q_q, hb_q_d;
  logic                cur_vld_q, cur_vld_d;
  logic                hb_vld_q, hb_vld_d;
  // Read-in-flight marker: bit 0 set when an address is issued, data is
  // valid on ram_dout_* while the marker sits in the top bit.
  logic [READ_LATENCY:0] rd_pipe_q, rd_pipe_d;

  logic land, accept, at_end, is_last;

  assign land    = rd_pipe_q[READ_LATENCY];
  assign accept  = cur_vld_q & smp_ready;
  assign at_end  = (bit_q == 6'd35);
  assign is_last = at_end && (emit_left_q == 9'd1);

  assign ram_addr  = addr_q;
  assign smp_valid = cur_vld_q;
  assign smp_i     = sh_i_q[0];
  assign smp_q     = sh_q_q[0];
  assign smp_last  = cur_vld_q & is_last;
  assign busy      = (state_q == FETCH) || (state_q == STREAM);
  assign done      = (state_q == FINISH);

  // Next-state, read issue, word loading and bit shifting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_left_d   = rd_left_q;
    emit_left_d = emit_left_q;
    bit_d       = bit_q;
    sh_i_d      = sh_i_q;
    sh_q_d      = sh_q_q;
    hb_i_d      = hb_i_q;
    hb_q_d      = hb_q_q;
    cur_vld_d   = cur_vld_q;
    hb_vld_d    = hb_vld_q;
    rd_pipe_d   = {rd_pipe_q[READ_LATENCY-1:0], 1'b0};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != 9'd0) begin
            state_d      = FETCH;
            addr_d       = start_addr;
            rd_left_d    = num_words - 9'd1;
            emit_left_d  = num_words;
            bit_d        = 6'd0;
            rd_pipe_d[0] = 1'b1;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FETCH, STREAM: begin
        // Returning data goes straight to the shifter if it is empty,
        // otherwise it waits in the holding buffer.
        if (land && !cur_vld_q) begin
          sh_i_d    = ram_dout_i;
          sh_q_d    = ram_dout_q;
          cur_vld_d = 1'b1;
          state_d   = STREAM;
        end else if (land) begin
          hb_i_d   = ram_dout_i;
          hb_q_d   = ram_dout_q;
          hb_vld_d = 1'b1;
        end
        if (accept) begin
          if (at_end) begin
            bit_d       = 6'd0;
            emit_left_d = emit_left_q - 9'd1;
            if (is_last) begin
              cur_vld_d = 1'b0;
              state_d   = FINISH;
            end else if (hb_vld_q) begin
              sh_i_d   = hb_i_q;
              sh_q_d   = hb_q_q;
              hb_vld_d = 1'b0;
            end else if (land) begin
              sh_i_d   = ram_dout_i;
              sh_q_d   = ram_dout_q;
              hb_vld_d = 1'b0;
            end else begin
              cur_vld_d = 1'b0;
            end
          end else begin
            sh_i_d = {1'b0, sh_i_q[35:1]};
            sh_q_d = {1'b0, sh_q_q[35:1]};
            bit_d  = bit_q + 6'd1;
          end
        end
        // Prefetch: one read in flight at most, only into an empty buffer.
        if (state_q == STREAM && rd_left_q != 9'd0 && rd_pipe_q == '0 && !hb_vld_q) begin
          addr_d       = addr_q + 9'd1;
          rd_left_d    = rd_left_q - 9'd1;
          rd_pipe_d[0] = 1'b1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort wins over everything else in any active state.
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      cur_vld_d = 1'b0;
      hb_vld_d  = 1'b0;
      rd_pipe_d = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_left_q   <= '0;
      emit_left_q <= '0;
      bit_q       <= '0;
      sh_i_q      <= '0;
      sh_q_q      <= '0;
      hb_i_q      <= '0;
      hb_q_q      <= '0;
      cur_vld_q   <= 1'b0;
      hb_vld_q    <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_left_q   <= rd_left_d;
      emit_left_q <= emit_left_d;
      bit_q       <= bit_d;
      sh_i_q      <= sh_i_d;
      sh_q_q      <= sh_q_d;
      hb_i_q      <= hb_i_d;
      hb_q_q      <= hb_q_d;
      cur_vld_q   <= cur_vld_d;
      hb_vld_q    <= hb_vld_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

endmodule

// File: tb/tb_iq_buf_reader.sv
// Bench for iq_buf_reader: two instances (read latency 1 and 2) exercised in
// turn against a sample-sequence model built from the RAM contents.
module tb_iq_buf_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        st[2], ab[2], rdy[2];
  logic [8:0]  sa[2], nw[2], ra[2];
  logic [35:0] di[2], dq[2];
  logic        sv[2], si[2], sq[2], sl[2], bz[2], dn[2];

  logic [35:0] mem_i[512], mem_q[512];
  logic [35:0] d1i[2], d1q[2], d2i[2], d2q[2];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int act = 0;
  bit rnd_rdy = 1'b0;
  bit mon_en = 1'b0;

  int acc_cnt, done_cnt, busy_cyc, first_cyc, last_cyc, done_cyc;
  bit p_stall;
  logic [2:0] p_bits;
  logic [2:0] expq[$];

  always #5 clk = ~clk;

  iq_buf_reader #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]),
    .start_addr(sa[0]), .num_words(nw[0]), .ram_addr(ra[0]),
    .ram_dout_i(di[0]), .ram_dout_q(dq[0]), .smp_valid(sv[0]),
    .smp_ready(rdy[0]), .smp_i(si[0]), .smp_q(sq[0]), .smp_last(sl[0]),
    .busy(bz[0]), .done(dn[0]));

  iq_buf_reader #(.READ_LATENCY(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]),
    .start_addr(sa[1]), .num_words(nw[1]), .ram_addr(ra[1]),
    .ram_dout_i(di[1]), .ram_dout_q(dq[1]), .smp_valid(sv[1]),
    .smp_ready(rdy[1]), .smp_i(si[1]), .smp_q(sq[1]), .smp_last(sl[1]),
    .busy(bz[1]), .done(dn[1]));

  // Synchronous BSRAM models: one and two register stages.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      d1i[g] <= mem_i[ra[g]];
      d1q[g] <= mem_q[ra[g]];
      d2i[g] <= d1i[g];
      d2q[g] <= d1q[g];
    end
  end
  always_comb begin
    di[0] = d1i[0]; dq[0] = d1q[0];
    di[1] = d2i[1]; dq[1] = d2q[1];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: random or held high for the active instance.
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++)
      rdy[g] = (g == act && rnd_rdy) ? 1'($urandom % 2) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Monitor: accepted samples vs model, stall stability, done/busy tracking.
  always @(negedge clk) begin
    logic [2:0] e;
    if (mon_en) begin
      if (bz[act]) busy_cyc++;
      if (dn[act]) begin done_cnt++; done_cyc = cyc; end
      if (p_stall) begin
        chk("stall_vld", 64'(sv[act]), 64'd1);
        chk("stall_bits", 64'({si[act], sq[act], sl[act]}), 64'(p_bits));
      end
      if (sv[act] && rdy[act]) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (expq.size() == 0) chk("extra_smp", 64'd1, 64'd0);
        else begin
          e = expq.pop_front();
          chk("smp", 64'({si[act], sq[act], sl[act]}), 64'(e));
        end
        acc_cnt++;
        last_cyc = cyc;
      end
      p_stall = sv[act] && !rdy[act] && !ab[act];
      p_bits  = {si[act], sq[act], sl[act]};
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic build_exp(input int a0, input int n);
    logic [8:0] a;
    expq.delete();
    for (int w = 0; w < n; w++) begin
      a = 9'((a0 + w) % 512);
      for (int k = 0; k < 36; k++)
        expq.push_back({mem_i[a][k], mem_q[a][k], (w == n - 1 && k == 35)});
    end
    acc_cnt = 0; done_cnt = 0; busy_cyc = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic do_start(input int a0, input int n);
    @(posedge clk); #1;
    sa[act] = 9'(a0); nw[act] = 9'(n); st[act] = 1'b1;
    @(posedge clk); #1;
    st[act] = 1'b0;
  endtask

  // One playback run; abort_at>0 aborts after that many accepted samples,
  // restart pulses a conflicting start mid-run that must be ignored.
  task automatic play(input int a0, input int n, input bit rr, input int abort_at, input bit restart);
    int t0, k;
    build_exp(a0, n);
    rnd_rdy = rr;
    mon_en = 1'b1;
    t0 = cyc;
    do_start(a0, n);
    if (restart) begin
      repeat (20) @(posedge clk);
      #1 sa[act] = 9'd0; nw[act] = 9'd7; st[act] = 1'b1;
      @(posedge clk); #1 st[act] = 1'b0;
    end
    if (abort_at > 0) begin
      k = 0;
      while (acc_cnt < abort_at && k < 3000) begin @(posedge clk); k++; end
      chk("abort_tmo", 64'(acc_cnt >= abort_at), 64'd1);
      #1 ab[act] = 1'b1;
      @(posedge clk); #1 ab[act] = 1'b0;
      @(negedge clk);
      chk("abort_vld", 64'(sv[act]), 64'd0);
      chk("abort_busy", 64'(bz[act]), 64'd0);
      repeat (20) @(posedge clk);
      chk("abort_done", 64'(done_cnt), 64'd0);
      mon_en = 1'b0;
      return;
    end
    k = 0;
    while (done_cnt == 0 && k < 3000) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("done_cnt", 64'(done_cnt), 64'd1);
    chk("smp_cnt", 64'(acc_cnt), 64'(36 * n));
    chk("exp_left", 64'(expq.size()), 64'd0);
    if (n > 0) begin
      chk("last_addr", 64'(ra[act]), 64'((a0 + n - 1) % 512));
      chk("done_lat", 64'(done_cyc - last_cyc), 64'd1);
      if (!rr) chk("no_gap", 64'(last_cyc - first_cyc + 1), 64'(36 * n));
    end else begin
      chk("zero_busy", 64'(busy_cyc <= 2), 64'd1);
      chk("zero_done_lat", 64'(done_cyc - t0 <= 3), 64'd1);
    end
  endtask

  task automatic reset_mid_run();
    int k;
    build_exp(50, 4);
    rnd_rdy = 1'b0;
    mon_en = 1'b1;
    do_start(50, 4);
    k = 0;
    while (acc_cnt < 50 && k < 3000) begin @(posedge clk); k++; end
    chk("rst_tmo", 64'(acc_cnt >= 50), 64'd1);
    mon_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_async", 64'({sv[act], si[act], sq[act], sl[act], bz[act], dn[act], ra[act]}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle", 64'({sv[act], bz[act], dn[act]}), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      st[g] = 1'b0; ab[g] = 1'b0; sa[g] = '0; nw[g] = '0; rdy[g] = 1'b1;
    end
    for (int a = 0; a < 512; a++) begin
      mem_i[a] = {4'($urandom), $urandom};
      mem_q[a] = {4'($urandom), $urandom};
    end
    mem_i[0] = 36'h0_0000_0001;
    mem_q[0] = 36'h8_0000_0000;
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk("reset", 64'({sv[g], si[g], sq[g], sl[g], bz[g], dn[g], ra[g]}), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int d = 0; d < 2; d++) begin
      act = d;
      repeat (3) @(posedge clk);
      play(0, 1, 1'b0, 0, 1'b0);
      play(510, 3, 1'b0, 0, 1'b0);
      play(37, 0, 1'b0, 0, 1'b0);
      play(100, 4, 1'b1, 0, 1'b1);
      play(200, 4, 1'b1, 40, 1'b0);
      play(300, 1, 1'b0, 0, 1'b0);
      reset_mid_run();
      play(5, 2, 1'b1, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
